// File: rtl/jtag_tap_master_if.sv
// Command/response channel between a requester and jtag_tap_master.
// master = requester, slave = the TAP master block.
interface jtag_tap_master_if #(
  parameter int MAX_LEN = 32
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tap_master.sv
// JTAG host: turns reset / IR scan / DR scan commands into TCK/TMS/TDI sequences, returns TDO bits.
// Optional TRSTn pin and pulse on reset commands when JTAG_MASTER_TRST_EN is defined.
module jtag_tap_master #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  jtag_tap_master_if.slave cmd_if,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  input  logic             TDO
`ifdef JTAG_MASTER_TRST_EN
  ,
  output logic             TRSTn
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CYC_W = $clog2(MAX_LEN + 7);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_RST = 2'd0;
  localparam logic [1:0] OP_IR  = 2'd1;
  localparam logic [1:0] OP_DR  = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  // Number of TCK cycles a command takes.
  function automatic logic [CYC_W-1:0] total_cyc(input logic [1:0] op, input logic [CYC_W-1:0] n);
    logic [CYC_W-1:0] t;
    case (op)
      OP_RST:  t = CYC_W'(6);
      OP_IR:   t = n + CYC_W'(6);
      OP_DR:   t = n + CYC_W'(5);
      default: t = '0;
    endcase
    return t;
  endfunction

  // {TMS, TDI} for TCK cycle idx of a command.
  function automatic logic [1:0] pins_at(input logic [1:0] op, input logic [CYC_W-1:0] n,
                                         input logic [CYC_W-1:0] idx, input logic [MAX_LEN-1:0] d);
    logic [CYC_W-1:0]   pre;
    logic [CYC_W-1:0]   b;
    logic [MAX_LEN-1:0] sh;
    logic               tms;
    logic               tdi;
    pre = (op == OP_IR) ? CYC_W'(4) : CYC_W'(3);
    b   = idx - pre;
    sh  = d >> b;
    tms = 1'b0;
    tdi = 1'b0;
    case (op)
      OP_RST: tms = (idx < CYC_W'(5));
      OP_IR, OP_DR: begin
        if (idx < pre) begin
          tms = (op == OP_IR) ? (idx < CYC_W'(2)) : (idx == '0);
        end else if (idx < pre + n) begin
          tms = (idx == pre + n - CYC_W'(1));
          tdi = sh[0];
        end else begin
          tms = (idx == pre + n);
        end
      end
      default: ;
    endcase
    return {tms, tdi};
  endfunction

  state_e             state_q, state_d;
  logic               tck_q, tms_q, tdi_q;
  logic [DIV_W-1:0]   div_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [1:0]         op_q;
  logic [CYC_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] rsp_data_q;

  logic               accept;
  logic               tck_edge, tck_rise, tck_fall;
  logic               last_cyc;
  logic [CYC_W-1:0]   len_w;
  logic [CYC_W-1:0]   pre_w;
  logic [CYC_W-1:0]   sbit;
  logic               in_shift;

  // Zero-length scans become 1 bit; oversize scans are clamped.
  always_comb begin
    len_w = CYC_W'(cmd_if.cmd_len);
    if (cmd_if.cmd_len == '0)
      len_w = CYC_W'(1);
    else if (cmd_if.cmd_len > LEN_W'(MAX_LEN))
      len_w = CYC_W'(MAX_LEN);
  end

  assign accept   = cmd_if.cmd_valid && (state_q == S_IDLE);
  assign tck_edge = (state_q == S_SHIFT) && (div_q == DIV_MAX);
  assign tck_rise = tck_edge && !tck_q;
  assign tck_fall = tck_edge && tck_q;
  assign last_cyc = (cyc_q == total_cyc(op_q, len_q) - CYC_W'(1));

  assign pre_w    = (op_q == OP_IR) ? CYC_W'(4) : CYC_W'(3);
  assign sbit     = cyc_q - pre_w;
  assign in_shift = ((op_q == OP_IR) || (op_q == OP_DR)) &&
                    (cyc_q >= pre_w) && (cyc_q < pre_w + len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_if.cmd_valid) state_d = (cmd_if.cmd_op == OP_RSV) ? S_DONE : S_SHIFT;
      S_SHIFT: if (tck_fall && last_cyc) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_if.cmd_ready = 1'b0;
    cmd_if.rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  cmd_if.cmd_ready = 1'b1;
      S_DONE:  cmd_if.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Pin sequencer: pins move on the TCK falling edge, TDO is taken on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      div_q      <= '0;
      cyc_q      <= '0;
      op_q       <= OP_RST;
      len_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else if (accept) begin
      op_q       <= cmd_if.cmd_op;
      len_q      <= len_w;
      data_q     <= cmd_if.cmd_data;
      rsp_data_q <= '0;
      cyc_q      <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      if (cmd_if.cmd_op != OP_RSV)
        {tms_q, tdi_q} <= pins_at(cmd_if.cmd_op, len_w, '0, cmd_if.cmd_data);
    end else if (state_q == S_SHIFT) begin
      if (tck_edge) begin
        div_q <= '0;
        tck_q <= ~tck_q;
        if (tck_rise && in_shift)
          rsp_data_q <= rsp_data_q | (MAX_LEN'(TDO) << sbit);
        if (tck_fall && !last_cyc) begin
          cyc_q          <= cyc_q + CYC_W'(1);
          {tms_q, tdi_q} <= pins_at(op_q, len_q, cyc_q + CYC_W'(1), data_q);
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign TCK             = tck_q;
  assign TMS             = tms_q;
  assign TDI             = tdi_q;
  assign cmd_if.rsp_data = rsp_data_q;

`ifdef JTAG_MASTER_TRST_EN
  // TRSTn covers the first two TCK cycles of a reset command.
  logic trstn_q;
  always_ff @(posedge clk) begin
    if (rst)
      trstn_q <= 1'b1;
    else if (accept && cmd_if.cmd_op == OP_RST)
      trstn_q <= 1'b0;
    else if (tck_fall && cyc_q == CYC_W'(1))
      trstn_q <= 1'b1;
  end
  assign TRSTn = trstn_q;
`endif

endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master: behavioural TAP target (IDCODE/BYPASS, IR width 4) plus loopback.
module tb_jtag_tap_master;

  localparam logic [31:0] IDCODE    = 32'hF00ED093;
  localparam logic [3:0]  IR_IDCODE = 4'h1;

  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        loop_a = 1'b0;

  logic tck_a, tms_a, tdi_a, tdo_a, trstn_a;
  logic tck_b, tms_b, tdi_b, tdo_b;
  logic        cur_ready, cur_rsp_valid;
  logic [31:0] cur_rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtag_tap_master_if #(.MAX_LEN(32)) ifa ();
  jtag_tap_master_if #(.MAX_LEN(32)) ifb ();

  assign ifa.cmd_valid = cmd_valid & ~sel;
  assign ifa.cmd_op    = cmd_op;
  assign ifa.cmd_len   = cmd_len;
  assign ifa.cmd_data  = cmd_data;
  assign ifb.cmd_valid = cmd_valid & sel;
  assign ifb.cmd_op    = cmd_op;
  assign ifb.cmd_len   = cmd_len;
  assign ifb.cmd_data  = cmd_data;

  assign cur_ready     = sel ? ifb.cmd_ready : ifa.cmd_ready;
  assign cur_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign cur_rsp_data  = sel ? ifb.rsp_data  : ifa.rsp_data;

  logic tap_tdo = 1'b0;
  assign tdo_a = loop_a ? tdi_a : tap_tdo;
  assign tdo_b = tdi_b;

`ifdef JTAG_MASTER_TRST_EN
  logic trstn_b;
`else
  assign trstn_a = 1'b1;
`endif

  jtag_tap_master #(.CLK_DIV(3), .MAX_LEN(32)) u_dut (
    .clk(clk), .rst(rst), .cmd_if(ifa.slave),
    .TCK(tck_a), .TMS(tms_a), .TDI(tdi_a), .TDO(tdo_a)
`ifdef JTAG_MASTER_TRST_EN
    , .TRSTn(trstn_a)
`endif
  );

  jtag_tap_master #(.CLK_DIV(1), .MAX_LEN(32)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_if(ifb.slave),
    .TCK(tck_b), .TMS(tms_b), .TDI(tdi_b), .TDO(tdo_b)
`ifdef JTAG_MASTER_TRST_EN
    , .TRSTn(trstn_b)
`endif
  );

  // Target TAP
  tap_e        tap_st = PADR;
  logic [3:0]  tap_ir = IR_IDCODE;
  logic [3:0]  ir_sr  = 4'h0;
  logic [31:0] dr_sr  = 32'h0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:        return m ? TLR   : RTI;
      RTI:        return m ? SELDR : RTI;
      SELDR:      return m ? SELIR : CAPDR;
      CAPDR:      return m ? EX1DR : SHDR;
      SHDR:       return m ? EX1DR : SHDR;
      EX1DR:      return m ? UPDR  : PADR;
      PADR:       return m ? EX2DR : PADR;
      EX2DR:      return m ? UPDR  : SHDR;
      UPDR, UPIR: return m ? SELDR : RTI;
      SELIR:      return m ? TLR   : CAPIR;
      CAPIR:      return m ? EX1IR : SHIR;
      SHIR:       return m ? EX1IR : SHIR;
      EX1IR:      return m ? UPIR  : PAIR;
      PAIR:       return m ? EX2IR : PAIR;
      EX2IR:      return m ? UPIR  : SHIR;
      default:    return TLR;
    endcase
  endfunction

  always @(posedge tck_a) begin
    if (!trstn_a) begin
      tap_st <= TLR;
      tap_ir <= IR_IDCODE;
    end else begin
      case (tap_st)
        TLR:   tap_ir <= IR_IDCODE;
        CAPDR: dr_sr  <= (tap_ir == IR_IDCODE) ? IDCODE : 32'h0;
        SHDR:  dr_sr  <= (tap_ir == IR_IDCODE) ? {tdi_a, dr_sr[31:1]} : {31'h0, tdi_a};
        CAPIR: ir_sr  <= 4'b0001;
        SHIR:  ir_sr  <= {tdi_a, ir_sr[3:1]};
        UPIR:  tap_ir <= ir_sr;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms_a);
    end
  end

  always @(negedge tck_a)
    tap_tdo <= (tap_st == SHDR) ? dr_sr[0] : ((tap_st == SHIR) ? ir_sr[0] : 1'b0);

  // TCK rising-edge monitor on the main instance
  int         mon_cnt = 0;
  logic [5:0] mon_tms = 6'h0;
  always @(posedge tck_a) begin
    mon_cnt <= mon_cnt + 1;
    mon_tms <= {mon_tms[4:0], tms_a};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic s, input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] d, output logic [31:0] rsp, output int lat);
    int w;
    sel = s;
    w = 0;
    @(negedge clk);
    while (!cur_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cur_rsp_valid && lat < 1000);
    chk("rsp_seen", 64'(cur_rsp_valid), 64'd1);
    rsp = cur_rsp_data;
  endtask

  initial begin
    logic [31:0] rsp;
    int          lat;
    int          t0;
    int          pulses;

    repeat (3) @(negedge clk);
    chk("rst_tck",       64'(tck_a),         64'd0);
    chk("rst_tms",       64'(tms_a),         64'd1);
    chk("rst_tdi",       64'(tdi_a),         64'd0);
    chk("rst_ready",     64'(ifa.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
    chk("rst_rsp_data",  64'(ifa.rsp_data),  64'd0);
`ifdef JTAG_MASTER_TRST_EN
    chk("rst_trstn",     64'(trstn_b),       64'd1);
`endif
    rst = 1'b0;

    // TAP reset: 6 TCK edges, TMS 1,1,1,1,1,0
    t0 = mon_cnt;
    run_cmd(1'b0, 2'd0, 6'd0, 32'h0, rsp, lat);
    chk("reset_lat",      64'(lat),           64'd37);
    chk("reset_edges",    64'(mon_cnt - t0),  64'd6);
    chk("reset_tms_seq",  64'(mon_tms),       64'h3E);
    chk("reset_tck_low",  64'(tck_a),         64'd0);
    chk("reset_tap_rti",  64'(tap_st),        64'(RTI));
    @(negedge clk);
    chk("reset_ready_after", 64'(ifa.cmd_ready), 64'd1);

    // IDCODE twice
    run_cmd(1'b0, 2'd2, 6'd32, 32'h7F, rsp, lat);
    chk("idcode1",     64'(rsp), 64'hF00ED093);
    chk("idcode1_lat", 64'(lat), 64'd223);
    chk("idcode_tap_rti", 64'(tap_st), 64'(RTI));
    repeat (3) @(negedge clk);
    chk("rsp_hold", 64'(ifa.rsp_data), 64'hF00ED093);
    run_cmd(1'b0, 2'd2, 6'd32, 32'h7F, rsp, lat);
    chk("idcode2", 64'(rsp), 64'hF00ED093);

    // BYPASS: IR capture returns 0001, one-bit bypass delays the data
    run_cmd(1'b0, 2'd1, 6'd4, 32'hF, rsp, lat);
    chk("ir_capture", 64'(rsp), 64'h1);
    chk("ir_lat",     64'(lat), 64'd61);
    chk("ir_tap_rti", 64'(tap_st), 64'(RTI));
    run_cmd(1'b0, 2'd2, 6'd8, 32'hA5, rsp, lat);
    chk("bypass_dr", 64'(rsp), 64'h4A);

    // Loopback on the CLK_DIV=3 instance, including length boundaries
    loop_a = 1'b1;
    run_cmd(1'b0, 2'd2, 6'd8, 32'hA5, rsp, lat);
    chk("loop_a5",     64'(rsp), 64'hA5);
    chk("loop_a5_lat", 64'(lat), 64'd79);
    run_cmd(1'b0, 2'd2, 6'd0, 32'h3, rsp, lat);
    chk("len0_data", 64'(rsp), 64'h1);
    chk("len0_lat",  64'(lat), 64'd37);
    run_cmd(1'b0, 2'd2, 6'd37, 32'hDEADBEEF, rsp, lat);
    chk("lenmax_data", 64'(rsp), 64'hDEADBEEF);
    chk("lenmax_lat",  64'(lat), 64'd223);
    loop_a = 1'b0;

    // Loopback on the CLK_DIV=1 instance
    run_cmd(1'b1, 2'd2, 6'd8, 32'hA5, rsp, lat);
    chk("b_loop_a5",     64'(rsp), 64'hA5);
    chk("b_loop_a5_lat", 64'(lat), 64'd27);

    // Reserved op with cmd_valid held through DONE
    sel = 1'b0;
    @(negedge clk);
    chk("b2b_ready0", 64'(ifa.cmd_ready), 64'd1);
    t0 = mon_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = 6'd8;
    cmd_data  = 32'hFFFF;
    @(negedge clk);
    chk("b2b_v1",   64'(ifa.rsp_valid), 64'd1);
    chk("b2b_r1",   64'(ifa.cmd_ready), 64'd0);
    chk("rsv_data", 64'(ifa.rsp_data),  64'd0);
    @(negedge clk);
    chk("b2b_v2", 64'(ifa.rsp_valid), 64'd0);
    chk("b2b_r2", 64'(ifa.cmd_ready), 64'd1);
    @(negedge clk);
    chk("b2b_v3", 64'(ifa.rsp_valid), 64'd1);
    chk("b2b_r3", 64'(ifa.cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    chk("rsv_no_tck", 64'(mon_cnt - t0), 64'd0);

    // Reset in the middle of a DR scan
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_len   = 6'd32;
    cmd_data  = 32'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tck",   64'(tck_a),         64'd0);
    chk("midrst_tms",   64'(tms_a),         64'd1);
    chk("midrst_ready", 64'(ifa.cmd_ready), 64'd1);
    chk("midrst_rspv",  64'(ifa.rsp_valid), 64'd0);
    rst = 1'b0;
    t0 = mon_cnt;
    pulses = 0;
    repeat (250) begin
      @(negedge clk);
      if (ifa.rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", 64'(pulses),        64'd0);
    chk("midrst_no_tck", 64'(mon_cnt - t0),  64'd0);
    run_cmd(1'b0, 2'd0, 6'd0, 32'h0, rsp, lat);
    run_cmd(1'b0, 2'd2, 6'd32, 32'h7F, rsp, lat);
    chk("midrst_idcode", 64'(rsp), 64'hF00ED093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
